// File: rtl/vector_scalar_mult.sv
// vector_scalar_mult: handshaked signed vector-by-scalar multiply with TILING multipliers per cycle and overflow flag
module vector_scalar_mult #(
  parameter int VECTOR_LEN        = 5,
  parameter int A_CELL_WIDTH      = 8,
  parameter int B_CELL_WIDTH      = 8,
  parameter int RESULT_CELL_WIDTH = 8,
  parameter int FRACTION_WIDTH    = 0,
  parameter int TILING            = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [VECTOR_LEN*A_CELL_WIDTH-1:0]    a,
  input  logic                                  a_valid,
  output logic                                  a_ready,
  input  logic [B_CELL_WIDTH-1:0]               b,
  input  logic                                  b_valid,
  output logic                                  b_ready,
  output logic [VECTOR_LEN*RESULT_CELL_WIDTH-1:0] result,
  output logic                                  result_valid,
  input  logic                                  result_ready,
  output logic                                  error
);
  localparam int P  = A_CELL_WIDTH + B_CELL_WIDTH;
  localparam int W  = P + RESULT_CELL_WIDTH;
  localparam int CW = $clog2(VECTOR_LEN + TILING) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [VECTOR_LEN*A_CELL_WIDTH-1:0] a_buf;
  logic signed [B_CELL_WIDTH-1:0] b_buf;
  logic a_set, b_set;
  logic [CW-1:0] counter;
  logic [TILING-1:0] hit, ovf;
  logic [TILING-1:0][RESULT_CELL_WIDTH-1:0] prod_q;
  assign a_ready = state == IDLE && !a_set;
  assign b_ready = state == IDLE && !b_set;
  assign result_valid = state == DONE;
  for (genvar t = 0; t < TILING; t++) begin : g_mul
    logic [CW-1:0] idx, sel;
    logic signed [A_CELL_WIDTH-1:0] a_el;
    logic signed [P-1:0] prod;
    logic signed [W-1:0] ext, shr;
    assign idx = counter + CW'(t);
    assign hit[t] = idx < CW'(VECTOR_LEN);
    assign sel = hit[t] ? idx : '0;
    assign a_el = a_buf[sel*A_CELL_WIDTH +: A_CELL_WIDTH];
    assign prod = P'(a_el) * P'(b_buf);
    assign ext = {{RESULT_CELL_WIDTH{prod[P-1]}}, prod};
    assign shr = ext >>> FRACTION_WIDTH;
    assign ovf[t] = hit[t] && !(&shr[W-1:RESULT_CELL_WIDTH-1] || !(|shr[W-1:RESULT_CELL_WIDTH-1]));
    assign prod_q[t] = shr[RESULT_CELL_WIDTH-1:0];
  end
  // operand capture, run sequencing and result/error accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      a_set   <= 1'b0;
      b_set   <= 1'b0;
      a_buf   <= '0;
      b_buf   <= '0;
      result  <= '0;
      error   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (a_valid && a_ready) begin
            a_buf <= a;
            a_set <= 1'b1;
          end
          if (b_valid && b_ready) begin
            b_buf <= b;
            b_set <= 1'b1;
          end
          if (a_set && b_set) begin
            state   <= CALC;
            result  <= '0;
            counter <= '0;
            error   <= 1'b0;
          end
        end
        CALC: begin
          for (int j = 0; j < TILING; j++)
            if (hit[j]) result[(int'(counter) + j)*RESULT_CELL_WIDTH +: RESULT_CELL_WIDTH] <= prod_q[j];
          error   <= error | (|ovf);
          counter <= counter + CW'(TILING);
          if (counter + CW'(TILING) >= CW'(VECTOR_LEN)) state <= DONE;
        end
        default: begin
          if (result_ready) begin
            state <= IDLE;
            a_set <= 1'b0;
            b_set <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule
